// File: rtl/mem_stage_lsu_if.sv
// MEM-stage bus: M-side instruction fields from the execute pipeline register,
// the stall back to the hazard unit, and the registered MEM/WB fields.
interface mem_stage_lsu_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        MemReadM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;

  logic        StallM;

  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic        FaultW;

  // Upstream pipeline side.
  modport master (
    output RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM,
    input  StallM,
    input  RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, FaultW
  );

  // Memory stage side.
  modport slave (
    input  RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM,
    output StallM,
    output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, FaultW
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: byte-addressed B/H/W loads and stores with sign/zero
// extension, fault detection, a configurable access latency that stalls the
// pipeline, and the MEM/WB pipeline register.
module mem_stage_lsu #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] INIT_WORD   = 32'h0000000B
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);
  localparam logic [CW-1:0] CNT_INIT = (MEM_LATENCY > 1) ? CW'(MEM_LATENCY - 2) : '0;

  typedef enum logic {IDLE, WAIT} state_t;

  // Contents are preloaded once at time zero; reset deliberately leaves them alone.
  logic [31:0] mem_reg [DEPTH_WORDS] = '{default: INIT_WORD};

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;

  logic        regwrite_reg;
  logic [1:0]  resultsrc_reg;
  logic [4:0]  rd_reg;
  logic [31:0] pcplus4_reg;
  logic [31:0] aluresult_reg;
  logic [31:0] readdata_reg;
  logic        fault_reg;

  logic [31:0]   addr;
  logic [2:0]    f3;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          access;
  logic          f3_legal;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic          good_access;
  logic          start_wait;
  logic          complete;

  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] load_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic        st_en;

  assign addr         = bus.ALU_ResultM;
  assign f3           = bus.Funct3M;
  assign word_idx     = addr[AW+1:2];
  assign lane         = addr[1:0];
  assign access       = bus.MemReadM | bus.MemWriteM;
  assign out_of_range = |addr[31:AW+2];
  assign misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                        ((f3 == 3'b010) && (addr[1:0] != 2'b00));

  // Unsigned-size encodings are only meaningful for loads.
  always_comb begin
    f3_legal = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~bus.MemWriteM;
      default:                f3_legal = 1'b0;
    endcase
  end

  assign fault = access && ((bus.MemReadM && bus.MemWriteM) || !f3_legal ||
                            misaligned || out_of_range);
  assign good_access = access && !fault;

  // Faulting or non-memory instructions never wait.
  assign start_wait = (state_reg == IDLE) && good_access && MULTI_CYCLE;
  assign complete   = ((state_reg == IDLE) && !start_wait) ||
                      ((state_reg == WAIT) && (cnt_reg == '0));
  assign bus.StallM = !rst && (start_wait || ((state_reg == WAIT) && (cnt_reg != '0)));

  assign rd_word = mem_reg[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Load data extraction with sign or zero extension.
  always_comb begin
    load_ext = '0;
    case (f3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_ext = rd_word;
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = '0;
    endcase
  end

  assign load_data = (bus.MemReadM && !fault) ? load_ext : '0;

  // Per-lane store enables and data; narrow stores replicate their data across lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign st_be[gi] = ((f3[1:0] == 2'b00) && (lane == LANE)) ||
                         ((f3[1:0] == 2'b01) && (addr[1] == LANE[1])) ||
                         (f3[1:0] == 2'b10);
      assign st_data[gi*8 +: 8] = (f3[1:0] == 2'b00) ? bus.WriteDataM[7:0] :
                                  (f3[1:0] == 2'b01) ? bus.WriteDataM[(gi%2)*8 +: 8] :
                                                       bus.WriteDataM[gi*8 +: 8];
    end
  endgenerate

  // A store lands once, on its completion edge; reset abandons it.
  assign st_en = !rst && complete && good_access && bus.MemWriteM;

  // Byte-enabled memory write.
  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem_reg[word_idx][b*8 +: 8] <= st_data[b*8 +: 8];
        end
      end
    end
  end

  // Latency FSM: IDLE accepts an access, WAIT counts down the remaining cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_wait) begin
            state_reg <= WAIT;
            cnt_reg   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: capture on completion, otherwise load a bubble.
  always_ff @(posedge clk) begin
    if (rst || !complete) begin
      regwrite_reg  <= 1'b0;
      resultsrc_reg <= '0;
      rd_reg        <= '0;
      pcplus4_reg   <= '0;
      aluresult_reg <= '0;
      readdata_reg  <= '0;
      fault_reg     <= 1'b0;
    end else begin
      regwrite_reg  <= bus.RegWriteM && !fault;
      resultsrc_reg <= bus.ResultSrcM;
      rd_reg        <= bus.RD_M;
      pcplus4_reg   <= bus.PCPlus4M;
      aluresult_reg <= bus.ALU_ResultM;
      readdata_reg  <= load_data;
      fault_reg     <= fault;
    end
  end

  assign bus.RegWriteW   = regwrite_reg;
  assign bus.ResultSrcW  = resultsrc_reg;
  assign bus.RD_W        = rd_reg;
  assign bus.PCPlus4W    = pcplus4_reg;
  assign bus.ALU_ResultW = aluresult_reg;
  assign bus.ReadDataW   = readdata_reg;
  assign bus.FaultW      = fault_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: one instance with single-cycle access, one with
// three-cycle access, both compared against a byte-array reference model.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_lsu_if if1 ();
  mem_stage_lsu_if if3 ();

  mem_stage_lsu #(.DEPTH_WORDS(256), .MEM_LATENCY(1), .INIT_WORD(32'h0000000B)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  mem_stage_lsu #(.DEPTH_WORDS(256), .MEM_LATENCY(3), .INIT_WORD(32'h0000000B)) dut3 (
    .clk(clk), .rst(rst), .bus(if3)
  );

  // Stimulus goes to the selected instance; the other sees an all-zero instruction.
  logic        sel;
  logic        m_rw, m_mw, m_mr;
  logic [1:0]  m_rs;
  logic [2:0]  m_f3;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_wd, m_addr;

  assign if1.RegWriteM   = !sel && m_rw;
  assign if1.MemWriteM   = !sel && m_mw;
  assign if1.MemReadM    = !sel && m_mr;
  assign if1.ResultSrcM  = sel ? 2'b0 : m_rs;
  assign if1.Funct3M     = sel ? 3'b0 : m_f3;
  assign if1.RD_M        = sel ? 5'b0 : m_rd;
  assign if1.PCPlus4M    = sel ? 32'b0 : m_pc;
  assign if1.WriteDataM  = sel ? 32'b0 : m_wd;
  assign if1.ALU_ResultM = sel ? 32'b0 : m_addr;

  assign if3.RegWriteM   = sel && m_rw;
  assign if3.MemWriteM   = sel && m_mw;
  assign if3.MemReadM    = sel && m_mr;
  assign if3.ResultSrcM  = sel ? m_rs : 2'b0;
  assign if3.Funct3M     = sel ? m_f3 : 3'b0;
  assign if3.RD_M        = sel ? m_rd : 5'b0;
  assign if3.PCPlus4M    = sel ? m_pc : 32'b0;
  assign if3.WriteDataM  = sel ? m_wd : 32'b0;
  assign if3.ALU_ResultM = sel ? m_addr : 32'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ops    = 0;

  // Reference memory: one byte array per instance, 4*256 bytes, little-endian.
  logic [7:0] ref_mem [2][1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic stall_of(input logic s);
    return s ? if3.StallM : if1.StallM;
  endfunction

  task automatic check_w(input logic s, input string tag, input logic rw, input logic [1:0] rs,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic flt);
    if (s) begin
      check({tag, ".RegWriteW"}, 32'(if3.RegWriteW), 32'(rw));
      check({tag, ".ResultSrcW"}, 32'(if3.ResultSrcW), 32'(rs));
      check({tag, ".RD_W"}, 32'(if3.RD_W), 32'(rd));
      check({tag, ".PCPlus4W"}, if3.PCPlus4W, pc);
      check({tag, ".ALU_ResultW"}, if3.ALU_ResultW, alu);
      check({tag, ".ReadDataW"}, if3.ReadDataW, rdata);
      check({tag, ".FaultW"}, 32'(if3.FaultW), 32'(flt));
    end else begin
      check({tag, ".RegWriteW"}, 32'(if1.RegWriteW), 32'(rw));
      check({tag, ".ResultSrcW"}, 32'(if1.ResultSrcW), 32'(rs));
      check({tag, ".RD_W"}, 32'(if1.RD_W), 32'(rd));
      check({tag, ".PCPlus4W"}, if1.PCPlus4W, pc);
      check({tag, ".ALU_ResultW"}, if1.ALU_ResultW, alu);
      check({tag, ".ReadDataW"}, if1.ReadDataW, rdata);
      check({tag, ".FaultW"}, 32'(if1.FaultW), 32'(flt));
    end
  endtask

  // Present one instruction at a falling edge, follow it through any stall,
  // then compare the MEM/WB fields against the model. Returns at a falling edge.
  task automatic run_op(input logic s, input string tag, input logic rw, input logic mw,
                        input logic mr, input logic [1:0] rs, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                        input logic [31:0] addr);
    logic        acc, flt;
    logic [31:0] exp_data;
    logic [7:0]  b0, b1, b2, b3;
    int          a, stalls, exp_stalls;
    acc = mr || mw;
    flt = 1'b0;
    if (acc) begin
      if (mr && mw) flt = 1'b1;
      if (mw && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) flt = 1'b1;
      if (mr && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) flt = 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) flt = 1'b1;
      if (f3 == 3'd2 && (addr % 4 != 0)) flt = 1'b1;
      if (addr >= 32'd1024) flt = 1'b1;
    end
    exp_data = 32'h0;
    if (mr && !flt) begin
      a  = int'(addr[9:0]);
      b0 = ref_mem[s][a];
      b1 = ref_mem[s][(a + 1) % 1024];
      b2 = ref_mem[s][(a + 2) % 1024];
      b3 = ref_mem[s][(a + 3) % 1024];
      case (f3)
        3'd0: exp_data = 32'($signed(b0));
        3'd1: exp_data = 32'($signed({b1, b0}));
        3'd2: exp_data = {b3, b2, b1, b0};
        3'd4: exp_data = {24'h0, b0};
        3'd5: exp_data = {16'h0, b1, b0};
        default: exp_data = 32'h0;
      endcase
    end
    exp_stalls = (acc && !flt && s) ? 2 : 0;

    sel = s; m_rw = rw; m_mw = mw; m_mr = mr; m_rs = rs; m_f3 = f3;
    m_rd = rd; m_pc = pc; m_wd = wd; m_addr = addr;
    #1;
    stalls = 0;
    while (stall_of(s) && stalls < 10) begin
      @(posedge clk);
      @(negedge clk);
      stalls++;
      check_w(s, {tag, ".bubble"}, 1'b0, 2'b0, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    end
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk);
    @(negedge clk);
    check_w(s, tag, rw && !flt, rs, rd, pc, addr, exp_data, flt);

    if (mw && !flt) begin
      a = int'(addr[9:0]);
      ref_mem[s][a] = wd[7:0];
      if (f3 == 3'd1 || f3 == 3'd2) ref_mem[s][a + 1] = wd[15:8];
      if (f3 == 3'd2) begin
        ref_mem[s][a + 2] = wd[23:16];
        ref_mem[s][a + 3] = wd[31:24];
      end
    end
    n_ops++;
    $display("op %0d %s lat=%0d rw=%0b mw=%0b mr=%0b f3=%0d addr=0x%08h wd=0x%08h fault=%0b rdata=0x%08h stalls=%0d",
             n_ops, tag, s ? 3 : 1, rw, mw, mr, f3, addr, wd, flt, exp_data, stalls);
  endtask

  task automatic clear_inputs();
    sel = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_mr = 1'b0; m_rs = 2'b0; m_f3 = 3'b0;
    m_rd = 5'b0; m_pc = 32'h0; m_wd = 32'h0; m_addr = 32'h0;
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int          kind;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[0][i] = (i % 4 == 0) ? 8'h0B : 8'h00;
      ref_mem[1][i] = (i % 4 == 0) ? 8'h0B : 8'h00;
    end
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_w(1'b0, "reset.l1", 1'b0, 2'b0, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check_w(1'b1, "reset.l3", 1'b0, 2'b0, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset.stall_l3", 32'(if3.StallM), 32'h0);
    rst = 1'b0;

    // Single-cycle instance: word, byte and halfword traffic.
    run_op(1'b0, "sw_10",  1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd0, 32'h104, 32'hDEADBEEF, 32'h10);
    run_op(1'b0, "lw_10",  1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd7, 32'h108, 32'h0, 32'h10);
    check("lw_10.const", if1.ReadDataW, 32'hDEADBEEF);
    run_op(1'b0, "sb_21",  1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 32'h10C, 32'h00000080, 32'h21);
    run_op(1'b0, "lb_21",  1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 5'd8, 32'h110, 32'h0, 32'h21);
    check("lb_21.const", if1.ReadDataW, 32'hFFFFFF80);
    run_op(1'b0, "lbu_21", 1'b1, 1'b0, 1'b1, 2'd1, 3'd4, 5'd9, 32'h114, 32'h0, 32'h21);
    check("lbu_21.const", if1.ReadDataW, 32'h00000080);
    run_op(1'b0, "lw_20",  1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd10, 32'h118, 32'h0, 32'h20);
    check("lw_20.const", if1.ReadDataW, 32'h0000800B);
    run_op(1'b0, "sh_22",  1'b0, 1'b1, 1'b0, 2'd0, 3'd1, 5'd0, 32'h11C, 32'h00008001, 32'h22);
    run_op(1'b0, "lh_22",  1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 5'd11, 32'h120, 32'h0, 32'h22);
    check("lh_22.const", if1.ReadDataW, 32'hFFFF8001);

    // Faults: misaligned, out of range, illegal store size, read+write together.
    run_op(1'b0, "lw_12",  1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd12, 32'h124, 32'h0, 32'h12);
    run_op(1'b0, "lh_13",  1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 5'd13, 32'h128, 32'h0, 32'h13);
    run_op(1'b0, "sw_400", 1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 5'd0, 32'h12C, 32'hCAFEF00D, 32'h400);
    check("sw_400.fault", 32'(if1.FaultW), 32'h1);
    run_op(1'b0, "sbu_30", 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 5'd0, 32'h130, 32'h000000FF, 32'h30);
    run_op(1'b0, "rw_34",  1'b1, 1'b1, 1'b1, 2'd1, 3'd2, 5'd14, 32'h134, 32'h11111111, 32'h34);
    run_op(1'b0, "lw_0",   1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd15, 32'h138, 32'h0, 32'h0);
    check("lw_0.const", if1.ReadDataW, 32'h0000000B);
    run_op(1'b0, "lw_30",  1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd16, 32'h13C, 32'h0, 32'h30);
    run_op(1'b0, "lw_34",  1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd17, 32'h140, 32'h0, 32'h34);
    run_op(1'b0, "lw_3fc", 1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd18, 32'h144, 32'h0, 32'h3FC);

    // Non-memory pass-through.
    run_op(1'b0, "alu_42", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd5, 32'h148, 32'h0, 32'h42);
    check("alu_42.rd", 32'(if1.RD_W), 32'd5);

    // Three-cycle instance: stalled load.
    run_op(1'b1, "l3_lw_0", 1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd3, 32'h200, 32'h0, 32'h0);
    check("l3_lw_0.const", if3.ReadDataW, 32'h0000000B);
    run_op(1'b1, "l3_lh_6", 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 5'd4, 32'h204, 32'h0, 32'h6);

    // Reset in the first WAIT cycle abandons a pending store.
    sel = 1'b1; m_rw = 1'b0; m_mw = 1'b1; m_mr = 1'b0; m_rs = 2'd0; m_f3 = 3'd2;
    m_rd = 5'd0; m_pc = 32'h208; m_wd = 32'h12345678; m_addr = 32'h8;
    #1;
    check("rst_wait.stall_before", 32'(if3.StallM), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("rst_wait.stall_in_wait", 32'(if3.StallM), 32'h1);
    rst = 1'b1;
    clear_inputs();
    #1;
    check("rst_wait.stall_during", 32'(if3.StallM), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_w(1'b1, "rst_wait", 1'b0, 2'b0, 5'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst_wait.stall_after", 32'(if3.StallM), 32'h0);
    run_op(1'b1, "l3_lw_8", 1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 5'd6, 32'h20C, 32'h0, 32'h8);
    check("l3_lw_8.const", if3.ReadDataW, 32'h0000000B);

    // Randomized traffic on both instances.
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 7));
      rf3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: rf3 = 3'd0;
          1: rf3 = 3'd1;
          2: rf3 = 3'd2;
          3: rf3 = 3'd4;
          default: rf3 = 3'd5;
        endcase
      end
      case ($urandom_range(0, 9))
        0:       raddr = 32'($urandom_range(1020, 1100));
        1:       raddr = 32'($urandom_range(0, 1023));
        2:       raddr = $urandom;
        default: raddr = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        if (rf3 == 3'd2) raddr = raddr & ~32'h3;
        if (rf3 == 3'd1 || rf3 == 3'd5) raddr = raddr & ~32'h1;
      end
      run_op(1'($urandom_range(0, 1)), "rand", 1'($urandom),
             (kind >= 3 && kind <= 5) || kind == 7, kind <= 2 || kind == 7,
             2'($urandom), rf3, 5'($urandom), $urandom, $urandom, raddr);
    end

    clear_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=0x%08h exp=0x%08h", n_ops, 32'h0);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
